// File: rtl/softmax_max_sub_if.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_max_sub_if
//  Description : Stream bundle between the softmax input feeder, the
//                max-subtract stage and the exponent datapath.
//                slave  - the max-subtract stage (consumes i_*, drives o_*)
//                master - the feeder/observer side (drives i_*, reads o_*)
//  Signals     : i_valid, i_data[DWIDTH]    - input element handshake
//                o_ready                    - stage accepts i_data this cycle
//                o_valid, o_int[INT_BIT],
//                o_frac[FRAC_BIT], o_last   - difference stream (o_valid is
//                                             the downstream enable)
//                o_max[DWIDTH]              - max of the vector being emitted
//  Revision    : 1.0 - initial release
// ============================================================================
interface softmax_max_sub_if #(
    parameter int DWIDTH   = 16,
    parameter int INT_BIT  = 5,
    parameter int FRAC_BIT = 11
);
    logic                i_valid;
    logic [DWIDTH-1:0]   i_data;
    logic                o_ready;
    logic                o_valid;
    logic [INT_BIT-1:0]  o_int;
    logic [FRAC_BIT-1:0] o_frac;
    logic                o_last;
    logic [DWIDTH-1:0]   o_max;

    modport slave (
        input  i_valid, i_data,
        output o_ready, o_valid, o_int, o_frac, o_last, o_max
    );

    modport master (
        output i_valid, i_data,
        input  o_ready, o_valid, o_int, o_frac, o_last, o_max
    );
endinterface
`default_nettype wire

// File: rtl/softmax_max_sub.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_max_sub
//  Description : Softmax front end. Buffers one vector of VEC_LEN signed
//                Q(INT_BIT).(FRAC_BIT) elements, finds the maximum, then
//                streams x - max split into a signed floor (o_int, to the
//                exp LUT) and an unsigned fraction (o_frac, to the PWL
//                stage). Every emitted value lies in [-16, 0]; differences
//                below -16 clamp to exactly -16.0.
//  Ports       : clk     - clock, rising edge
//                arst_n  - asynchronous active-low reset
//                bus     - softmax_max_sub_if.slave stream bundle
//  Options     : SOFTMAX_MAX_SUB_PINGPONG_EN - two buffer banks so one vector
//                loads while the other emits (one vector per VEC_LEN cycles).
//                Undefined: single bank, one vector per 2*VEC_LEN+1 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module softmax_max_sub #(
    parameter int DWIDTH   = 16,
    parameter int INT_BIT  = 5,
    parameter int FRAC_BIT = 11,
    parameter int VEC_LEN  = 16
) (
    input wire clk,
    input wire arst_n,
    softmax_max_sub_if.slave bus
);
    localparam int                 c_IDX_W    = $clog2(VEC_LEN);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(VEC_LEN - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam int                 c_SAT_MAG  = 16 << FRAC_BIT;
    localparam logic [INT_BIT-1:0] c_SAT_INT  = {1'b1, {(INT_BIT-1){1'b0}}};

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Registered outputs
    logic                r_ready;
    logic                r_valid;
    logic [INT_BIT-1:0]  r_int;
    logic [FRAC_BIT-1:0] r_frac;
    logic                r_last;
    logic [DWIDTH-1:0]   r_max;

    // Load side
    logic                w_accept;
    logic                w_fill;
    logic                w_ready_next;
    logic [DWIDTH-1:0]   w_max_next;
    logic [DWIDTH-1:0]   r_run_max;
    logic [c_IDX_W-1:0]  r_wr_idx;

    // Emit side
    logic                w_issue;
    logic                w_rd_last_elem;
    logic [DWIDTH-1:0]   w_rd_data;
    logic [DWIDTH-1:0]   w_cur_max;
    logic signed [DWIDTH:0] w_diff;
    logic                w_sat;
    logic [INT_BIT-1:0]  w_int;
    logic [FRAC_BIT-1:0] w_frac;

    assign w_accept = bus.i_valid && r_ready;
    assign w_fill   = w_accept && (r_wr_idx == c_LAST_IDX);

    // Running max; the first element of a vector seeds it so an all-negative
    // vector never sees a stale or zero maximum.
    always_comb begin
        w_max_next = bus.i_data;
        if ((r_wr_idx != '0) && ($signed(r_run_max) > $signed(bus.i_data))) begin
            w_max_next = r_run_max;
        end
    end

    // One extra bit keeps x - max exact for any pair of inputs. The floor split
    // falls out of two's complement: upper bits are floor(diff), lower bits
    // are the non-negative remainder.
    always_comb begin
        w_diff = $signed({w_rd_data[DWIDTH-1], w_rd_data})
               - $signed({w_cur_max[DWIDTH-1], w_cur_max});
        w_sat  = (int'(w_diff) < -c_SAT_MAG);
        w_int  = w_diff[DWIDTH-1:FRAC_BIT];
        w_frac = w_diff[FRAC_BIT-1:0];
        if (w_sat) begin
            w_int  = c_SAT_INT;
            w_frac = '0;
        end
    end

`ifdef SOFTMAX_MAX_SUB_PINGPONG_EN
    // ------------------------------------------------------------------
    // Two banks: r_wr_bank fills while r_rd_bank streams. A bank's full
    // flag is set by its last write and cleared by its last read, so the
    // emitter can chain straight into the other bank with no bubble.
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0]  r_buf [2][VEC_LEN];
    logic [DWIDTH-1:0]  r_bank_max [2];
    logic [1:0]         r_full;
    logic [1:0]         w_full_next;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic               w_wr_bank_next;
    logic               w_rd_bank_next;
    logic [c_IDX_W-1:0] r_rd_idx;

    assign w_issue        = (r_state == EMIT);
    assign w_rd_last_elem = (r_rd_idx == c_LAST_IDX);
    assign w_rd_data      = r_buf[r_rd_bank][r_rd_idx];
    assign w_cur_max      = r_bank_max[r_rd_bank];

    always_comb begin
        w_full_next    = r_full;
        w_wr_bank_next = r_wr_bank;
        w_rd_bank_next = r_rd_bank;
        w_state_next   = r_state;
        if (w_fill) begin
            w_full_next[r_wr_bank] = 1'b1;
            w_wr_bank_next         = ~r_wr_bank;
        end
        if (w_issue && w_rd_last_elem) begin
            w_full_next[r_rd_bank] = 1'b0;
            w_rd_bank_next         = ~r_rd_bank;
        end
        case (r_state)
            LOAD: begin
                if (w_full_next[w_rd_bank_next]) begin
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                if (w_rd_last_elem) begin
                    w_state_next = w_full_next[w_rd_bank_next] ? EMIT : LOAD;
                end
            end
            default: w_state_next = LOAD;
        endcase
        w_ready_next = ~w_full_next[w_wr_bank_next];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state       <= LOAD;
            r_ready       <= 1'b1;
            r_full        <= '0;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_idx      <= '0;
            r_rd_idx      <= '0;
            r_run_max     <= '0;
            r_bank_max[0] <= '0;
            r_bank_max[1] <= '0;
            r_max         <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ready   <= w_ready_next;
            r_full    <= w_full_next;
            r_wr_bank <= w_wr_bank_next;
            r_rd_bank <= w_rd_bank_next;
            if (w_accept) begin
                r_wr_idx  <= r_wr_idx + c_IDX_ONE;
                r_run_max <= w_max_next;
            end
            if (w_fill) begin
                r_bank_max[r_wr_bank] <= w_max_next;
            end
            if (w_issue) begin
                r_rd_idx <= r_rd_idx + c_IDX_ONE;
                // o_max follows the vector on the wire, so it changes
                // together with that vector's first output.
                if (r_rd_idx == '0) begin
                    r_max <= w_cur_max;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_bank][r_wr_idx] <= bus.i_data;
        end
    end
`else
    // ------------------------------------------------------------------
    // Single bank. r_rd_idx carries one extra bit: values 0..VEC_LEN-1
    // issue reads, VEC_LEN is the drain cycle in which the last output is
    // on the wire and o_ready is still low.
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0]  r_buf [VEC_LEN];
    logic [c_IDX_W:0]   r_rd_idx;

    assign w_issue        = (r_state == EMIT) && !r_rd_idx[c_IDX_W];
    assign w_rd_last_elem = (r_rd_idx[c_IDX_W-1:0] == c_LAST_IDX);
    assign w_rd_data      = r_buf[r_rd_idx[c_IDX_W-1:0]];
    assign w_cur_max      = r_max;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD: begin
                if (w_fill) begin
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                if (r_rd_idx[c_IDX_W]) begin
                    w_state_next = LOAD;
                end
            end
            default: w_state_next = LOAD;
        endcase
        w_ready_next = (w_state_next == LOAD);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= LOAD;
            r_ready   <= 1'b1;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_run_max <= '0;
            r_max     <= '0;
        end else begin
            r_state <= w_state_next;
            r_ready <= w_ready_next;
            if (w_accept) begin
                r_wr_idx  <= r_wr_idx + c_IDX_ONE;
                r_run_max <= w_max_next;
            end
            if (w_fill) begin
                r_max <= w_max_next;
            end
            if (r_state == EMIT) begin
                r_rd_idx <= r_rd_idx[c_IDX_W] ? '0 : r_rd_idx + {1'b0, c_IDX_ONE};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_idx] <= bus.i_data;
        end
    end
`endif

    // Output register: data fields only move when a new element is issued,
    // so they hold their last value while o_valid is low.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_valid <= 1'b0;
            r_int   <= '0;
            r_frac  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_int  <= w_int;
                r_frac <= w_frac;
                r_last <= w_rd_last_elem;
            end
        end
    end

    assign bus.o_ready = r_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_int   = r_int;
    assign bus.o_frac  = r_frac;
    assign bus.o_last  = r_last;
    assign bus.o_max   = r_max;

endmodule
`default_nettype wire

// File: tb/tb_softmax_max_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_softmax_max_sub
//  Description : Self-checking bench for softmax_max_sub. Directed vectors
//                from the test plan plus $urandom vectors, checked against
//                an integer-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_max_sub;
    localparam int DW  = 16;
    localparam int IB  = 5;
    localparam int FB  = 11;
    localparam int VL  = 16;
    localparam int SAT = 16 << FB;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    softmax_max_sub_if #(.DWIDTH(DW), .INT_BIT(IB), .FRAC_BIT(FB)) bus ();

    softmax_max_sub #(
        .DWIDTH  (DW),
        .INT_BIT (IB),
        .FRAC_BIT(FB),
        .VEC_LEN (VL)
    ) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IB-1:0] oint;
        logic [FB-1:0] ofrac;
        logic          olast;
        logic [DW-1:0] omax;
    } rec_t;

    rec_t exp_q[$];
    rec_t out_q[$];
    int   ready_runs[$];
    int   valid_runs[$];
    int   r_cnt = 0;
    int   v_cnt = 0;

    // Output collector and run-length tracker, sampled on the falling edge.
    always @(negedge clk) begin
        if (!arst_n) begin
            r_cnt = 0;
            v_cnt = 0;
        end else begin
            if (bus.o_valid) begin
                out_q.push_back(rec_t'({bus.o_int, bus.o_frac, bus.o_last, bus.o_max}));
                v_cnt++;
            end else if (v_cnt > 0) begin
                valid_runs.push_back(v_cnt);
                v_cnt = 0;
            end
            if (!bus.o_ready) begin
                r_cnt++;
            end else if (r_cnt > 0) begin
                ready_runs.push_back(r_cnt);
                r_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: value = x - max(x) in units of 2^-FB, clamped at -16.0,
    // then split into floor and remainder.
    function automatic void model(input logic [DW-1:0] v [VL]);
        int mx;
        int d;
        int ei;
        int ef;
        mx = int'($signed(v[0]));
        for (int i = 1; i < VL; i++) begin
            if (int'($signed(v[i])) > mx) mx = int'($signed(v[i]));
        end
        for (int i = 0; i < VL; i++) begin
            d = int'($signed(v[i])) - mx;
            if (d < -SAT) begin
                ei = -16;
                ef = 0;
            end else begin
                ei = d >>> FB;
                ef = d - ei * (1 << FB);
            end
            exp_q.push_back(rec_t'({IB'(ei), FB'(ef), (i == VL - 1), DW'(mx)}));
        end
    endfunction

    task automatic send(input logic [DW-1:0] x);
        int g = 0;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data  = x;
        while (!bus.o_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("ready_wait", 32'(g < 100), 32'd1);
    endtask

    task automatic send_vec(input logic [DW-1:0] v [VL]);
        model(v);
        for (int i = 0; i < VL; i++) send(v[i]);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int g = 0;
        while (out_q.size() < exp_q.size() && g < 400) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
    endtask

    task automatic compare_all(input string tag);
        rec_t o;
        rec_t e;
        while (exp_q.size() > 0 && out_q.size() > 0) begin
            e = exp_q.pop_front();
            o = out_q.pop_front();
            check({tag, "_int"},  32'(o.oint),  32'(e.oint));
            check({tag, "_frac"}, 32'(o.ofrac), 32'(e.ofrac));
            check({tag, "_last"}, 32'(o.olast), 32'(e.olast));
            check({tag, "_max"},  32'(o.omax),  32'(e.omax));
        end
        repeat (3) @(negedge clk);
        check({tag, "_extra"}, 32'(out_q.size()), 32'd0);
        exp_q.delete();
        out_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v [VL];
        int g;

        bus.i_valid = 1'b0;
        bus.i_data  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_int",   32'(bus.o_int),   32'd0);
        check("rst_frac",  32'(bus.o_frac),  32'd0);
        check("rst_last",  32'(bus.o_last),  32'd0);
        check("rst_max",   32'(bus.o_max),   32'd0);
        arst_n = 1'b1;

        // All elements 1.0, with first-output latency
        for (int i = 0; i < VL; i++) v[i] = 16'h0800;
        send_vec(v);
        @(negedge clk);
        bus.i_valid = 1'b0;
        check("lat_cycle1_valid", 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(bus.o_valid), 32'd1);
        check("ones_max_const",   32'(bus.o_max),   32'h0800);
        wait_out("ones");
        compare_all("ones");

        // 0.0 against max 0.5 -> -0.5
        v[0] = 16'h0000;
        v[1] = 16'h0400;
        for (int i = 2; i < VL; i++) v[i] = 16'($urandom_range(0, 16'h0400));
        send_vec(v);
        idle();
        wait_out("half");
        check("half_int_const",  32'(out_q[0].oint),  32'h1F);
        check("half_frac_const", 32'(out_q[0].ofrac), 32'd1024);
        compare_all("half");

        // Saturation and exact -1.0
        v[0] = 16'h8000;
        v[1] = 16'h77FF;
        v[2] = 16'h7FFF;
        for (int i = 3; i < VL; i++) v[i] = 16'($urandom);
        send_vec(v);
        idle();
        wait_out("sat");
        check("sat_int_const",    32'(out_q[0].oint),  32'h10);
        check("sat_frac_const",   32'(out_q[0].ofrac), 32'd0);
        check("minus1_int_const", 32'(out_q[1].oint),  32'h1F);
        check("minus1_frac_const",32'(out_q[1].ofrac), 32'd0);
        compare_all("sat");

        // All-negative vector, max -3.0
        for (int i = 0; i < VL; i++) v[i] = 16'($urandom_range(16'h8000, 16'hE7FF));
        v[5] = 16'hE800;
        send_vec(v);
        idle();
        wait_out("neg");
        check("neg_max_const",  32'(out_q[5].omax),  32'hE800);
        check("neg_int_const",  32'(out_q[5].oint),  32'd0);
        check("neg_frac_const", 32'(out_q[5].ofrac), 32'd0);
        compare_all("neg");

        // Random vectors: full range (heavy saturation) and narrow range
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < VL; i++) begin
                v[i] = (k < 2) ? 16'($urandom) : 16'($urandom_range(0, 16'h5FFF));
            end
            send_vec(v);
            idle();
            wait_out("rand");
            compare_all("rand");
        end

        // Reset in the middle of emission
        for (int i = 0; i < VL; i++) v[i] = 16'($urandom);
        send_vec(v);
        idle();
        g = 0;
        while (!bus.o_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("mid_rst_emitting", 32'(bus.o_valid), 32'd1);
        repeat (3) @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        exp_q.delete();
        out_q.delete();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < VL; i++) v[i] = 16'($urandom_range(16'h2000, 16'h7FFF));
        send_vec(v);
        idle();
        wait_out("post_rst");
        compare_all("post_rst");

        // Back-to-back vectors with i_valid held high
        ready_runs.delete();
        valid_runs.delete();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < VL; i++) v[i] = 16'($urandom_range(0, 16'h7FFF));
            send_vec(v);
        end
        idle();
        wait_out("b2b");
        compare_all("b2b");
        repeat (4) @(negedge clk);
`ifdef SOFTMAX_MAX_SUB_PINGPONG_EN
        check("b2b_valid_runs",  32'(valid_runs.size()), 32'd1);
        check("b2b_valid_run0",  32'(valid_runs[0]),     32'd32);
`else
        check("b2b_ready_runs",  32'(ready_runs.size()), 32'd2);
        check("b2b_ready_run0",  32'(ready_runs[0]),     32'd17);
        check("b2b_ready_run1",  32'(ready_runs[1]),     32'd17);
        check("b2b_valid_runs",  32'(valid_runs.size()), 32'd2);
        check("b2b_valid_run0",  32'(valid_runs[0]),     32'd16);
        check("b2b_valid_run1",  32'(valid_runs[1]),     32'd16);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
